// File: rtl/mouse_pos_tracker_pkg.sv
// Shared types, bit positions and widths for the PS/2 mouse position tracker.
// Optional MOUSE_ACCEL_EN adds the acceleration threshold constant.
package mouse_pos_tracker_pkg;

   typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_UPD} state_t;

   typedef struct packed {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } ps2_pkt_t;

   localparam int unsigned BTN_L = 0;
   localparam int unsigned BTN_R = 1;
   localparam int unsigned SYNC  = 3;
   localparam int unsigned XS    = 4;
   localparam int unsigned YS    = 5;
   localparam int unsigned XO    = 6;
   localparam int unsigned YO    = 7;

   localparam int unsigned SCREEN_XMAX = 799;
   localparam int unsigned SCREEN_YMAX = 599;
   localparam int unsigned COORD_W     = 12;
   localparam int unsigned SUM_W       = 14;

`ifdef MOUSE_ACCEL_EN
   localparam int unsigned ACCEL_THRESH = 8;
`endif

   // Saturate a signed sum into 0..maxv
   function automatic logic [COORD_W-1:0] clamp_axis(input logic signed [SUM_W-1:0] v,
                                                     input logic [COORD_W-1:0]     maxv);
      if (v[SUM_W-1]) return '0;
      if (v > $signed(SUM_W'(maxv))) return maxv;
      return v[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/mouse_pos_tracker_if.sv
// Byte-stream input and cursor/button output bundle of the mouse position tracker.
interface mouse_pos_tracker_if;
   import mouse_pos_tracker_pkg::*;

   logic [7:0]         rx_data;
   logic               rx_valid;
   logic [COORD_W-1:0] xpos;
   logic [COORD_W-1:0] ypos;
   logic               left;
   logic               right;
   logic               pkt_done;
   logic               sync_err;

   modport master (output rx_data, rx_valid,
                   input  xpos, ypos, left, right, pkt_done, sync_err);
   modport slave  (input  rx_data, rx_valid,
                   output xpos, ypos, left, right, pkt_done, sync_err);
endinterface

// File: rtl/mouse_pos_tracker_ps2_packet_fsm.sv
// Assembles 3-byte PS/2 mouse packets: sync-bit check on byte 0 and an
// inter-byte timeout that aborts a partial packet.
module mouse_pos_tracker_ps2_packet_fsm
   import mouse_pos_tracker_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic       clk100MHz,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output ps2_pkt_t   pkt,
   output logic       pkt_valid,
   output logic       sync_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC);

   state_t        state;
   logic [CW-1:0] tmo_cnt;

   // UPD shares the B0 handling so a byte arriving during the update slot is kept
   always_ff @(posedge clk100MHz or posedge rst) begin
      if (rst) begin
         state     <= ST_B0;
         pkt       <= '0;
         pkt_valid <= 1'b0;
         sync_err  <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         pkt_valid <= 1'b0;
         sync_err  <= 1'b0;
         case (state)
            ST_B0, ST_UPD: begin
               tmo_cnt <= '0;
               state   <= ST_B0;
               if (rx_valid) begin
                  if (rx_data[SYNC]) begin
                     pkt.b0 <= rx_data;
                     state  <= ST_B1;
                  end else begin
                     sync_err <= 1'b1;
                  end
               end
            end
            ST_B1: begin
               if (rx_valid) begin
                  pkt.b1  <= rx_data;
                  tmo_cnt <= '0;
                  state   <= ST_B2;
               end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  tmo_cnt  <= '0;
                  sync_err <= 1'b1;
                  state    <= ST_B0;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            ST_B2: begin
               if (rx_valid) begin
                  pkt.b2    <= rx_data;
                  pkt_valid <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= ST_UPD;
               end else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  tmo_cnt  <= '0;
                  sync_err <= 1'b1;
                  state    <= ST_B0;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            default: state <= ST_B0;
         endcase
      end
   end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Accumulates PS/2 mouse deltas into clamped absolute cursor coordinates plus buttons.
// Define MOUSE_ACCEL_EN to double deltas whose magnitude exceeds ACCEL_THRESH.
module mouse_pos_tracker
   import mouse_pos_tracker_pkg::*;
#(
   parameter int unsigned XMAX        = SCREEN_XMAX,
   parameter int unsigned YMAX        = SCREEN_YMAX,
   parameter int unsigned X_INIT      = 400,
   parameter int unsigned Y_INIT      = 300,
   parameter int unsigned TIMEOUT_CYC = 200000
) (
   input  logic                clk100MHz,
   input  logic                rst,
   mouse_pos_tracker_if.slave  bus
);

   ps2_pkt_t           pkt;
   logic               pkt_valid;
   logic               sync_err;
   logic [COORD_W-1:0] xpos_q, ypos_q;
   logic               left_q, right_q, pkt_done_q;
   logic signed [SUM_W-1:0] dx_c, dy_c, x_sum_c, y_sum_c;
   logic               unused_bits_c;

   mouse_pos_tracker_ps2_packet_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_fsm (
      .clk100MHz (clk100MHz),
      .rst       (rst),
      .rx_data   (bus.rx_data),
      .rx_valid  (bus.rx_valid),
      .pkt       (pkt),
      .pkt_valid (pkt_valid),
      .sync_err  (sync_err)
   );

`ifdef MOUSE_ACCEL_EN
   function automatic logic signed [SUM_W-1:0] accel(input logic signed [SUM_W-1:0] d);
      if (d > $signed(SUM_W'(ACCEL_THRESH)) || d < -$signed(SUM_W'(ACCEL_THRESH)))
         return d <<< 1;
      return d;
   endfunction
`endif

   // 9-bit deltas sign-extended to the 14-bit working width
   always_comb begin
      dx_c = {{(SUM_W-8){pkt.b0[XS]}}, pkt.b1};
      dy_c = {{(SUM_W-8){pkt.b0[YS]}}, pkt.b2};
`ifdef MOUSE_ACCEL_EN
      dx_c = accel(dx_c);
      dy_c = accel(dy_c);
`endif
      x_sum_c = $signed(SUM_W'(xpos_q)) + dx_c;
      y_sum_c = $signed(SUM_W'(ypos_q)) - dy_c;
   end

   assign unused_bits_c = ^{pkt.b0[2], pkt.b0[SYNC]};

   // Both axes commit on the same edge so the pair is always coherent downstream
   always_ff @(posedge clk100MHz or posedge rst) begin
      if (rst) begin
         xpos_q     <= COORD_W'(X_INIT);
         ypos_q     <= COORD_W'(Y_INIT);
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         pkt_done_q <= pkt_valid;
         if (pkt_valid) begin
            if (!pkt.b0[XO]) xpos_q <= clamp_axis(x_sum_c, COORD_W'(XMAX));
            if (!pkt.b0[YO]) ypos_q <= clamp_axis(y_sum_c, COORD_W'(YMAX));
            left_q  <= pkt.b0[BTN_L];
            right_q <= pkt.b0[BTN_R];
         end
      end
   end

   assign bus.xpos     = xpos_q;
   assign bus.ypos     = ypos_q;
   assign bus.left     = left_q;
   assign bus.right    = right_q;
   assign bus.pkt_done = pkt_done_q;
   assign bus.sync_err = sync_err;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed bench for mouse_pos_tracker with a scoreboard of expected cursor/button states.
// The inter-byte timeout is shortened to keep the run brief.
module tb_mouse_pos_tracker;

   localparam int unsigned TB_TMO = 200;

   typedef struct {
      int   x;
      int   y;
      logic l;
      logic r;
   } exp_t;

   logic clk100MHz;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   pkt_seen = 0;
   int   pkt_pushed = 0;
   int   sync_seen = 0;
   int   mx = 400;
   int   my = 300;
   exp_t sb[$];
   exp_t mon_e;

   mouse_pos_tracker_if bus();

   mouse_pos_tracker #(
      .TIMEOUT_CYC (TB_TMO)
   ) dut (
      .clk100MHz (clk100MHz),
      .rst       (rst),
      .bus       (bus)
   );

   initial begin
      clk100MHz = 1'b0;
      forever #5 clk100MHz = ~clk100MHz;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int mx_v);
      if (v < 0) return 0;
      if (v > mx_v) return mx_v;
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk100MHz);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk100MHz);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   // Drive a full packet and queue the state the tracker must reach
   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int   dx, dy;
      exp_t e;
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      dx = b0[4] ? int'(b1) - 256 : int'(b1);
      dy = b0[5] ? int'(b2) - 256 : int'(b2);
`ifdef MOUSE_ACCEL_EN
      if (dx > 8 || dx < -8) dx = dx * 2;
      if (dy > 8 || dy < -8) dy = dy * 2;
`endif
      if (!b0[6]) mx = clampi(mx + dx, 799);
      if (!b0[7]) my = clampi(my - dy, 599);
      e.x = mx;
      e.y = my;
      e.l = b0[0];
      e.r = b0[1];
      sb.push_back(e);
      pkt_pushed++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      mx = 400;
      my = 300;
   endtask

   always @(negedge clk100MHz) begin
      if (bus.sync_err === 1'b1) sync_seen++;
      if (bus.pkt_done === 1'b1) begin
         pkt_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_pkt_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_xpos",  32'(bus.xpos),  32'(mon_e.x));
            chk("sb_ypos",  32'(bus.ypos),  32'(mon_e.y));
            chk("sb_left",  32'(bus.left),  32'(mon_e.l));
            chk("sb_right", 32'(bus.right), 32'(mon_e.r));
         end
      end
   end

   initial begin
      int s0;
      rst          = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      idle(2);

      // reset state while rst held
      chk("rst_xpos", 32'(bus.xpos), 32'd400);
      chk("rst_ypos", 32'(bus.ypos), 32'd300);
      chk("rst_left", 32'(bus.left), 32'd0);
      chk("rst_right", 32'(bus.right), 32'd0);
      chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
      chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
      rst = 1'b0;
      idle(1);

      // basic packet and its two-cycle latency
      send_pkt(8'h09, 8'h0A, 8'h05);
      chk("lat_upd_no_done", 32'(bus.pkt_done), 32'd0);
      idle(1);
      chk("lat_done", 32'(bus.pkt_done), 32'd1);
      chk("lat_xpos", 32'(bus.xpos), 32'd410);
      chk("lat_ypos", 32'(bus.ypos), 32'd295);
      idle(1);
      chk("done_single_pulse", 32'(bus.pkt_done), 32'd0);
      idle(3);

      // saturation at 0 and YMAX
      do_reset();
      send_pkt(8'h38, 8'h00, 8'h00);
      idle(3);
      send_pkt(8'h38, 8'h00, 8'h00);
      idle(3);
      chk("clamp_x0", 32'(bus.xpos), 32'd0);
      chk("clamp_ymax", 32'(bus.ypos), 32'd599);

      // saturation at XMAX and 0
      do_reset();
      send_pkt(8'h08, 8'hFF, 8'hFF);
      idle(3);
      send_pkt(8'h08, 8'hFF, 8'hFF);
      idle(3);
      chk("clamp_xmax", 32'(bus.xpos), 32'd799);
      chk("clamp_y0", 32'(bus.ypos), 32'd0);

      // bad sync byte dropped
      do_reset();
      s0 = sync_seen;
      send_byte(8'h01);
      idle(2);
      chk("sync_drop_pulse", 32'(sync_seen - s0), 32'd1);
      send_pkt(8'h08, 8'h01, 8'h00);
      idle(3);
      chk("sync_recover_xpos", 32'(bus.xpos), 32'd401);

      // inter-byte timeout aborts the partial packet
      do_reset();
      s0 = sync_seen;
      send_byte(8'h08);
      send_byte(8'h05);
      idle(int'(TB_TMO) + 10);
      chk("timeout_pulse", 32'(sync_seen - s0), 32'd1);
      send_pkt(8'h08, 8'h02, 8'h00);
      idle(3);
      chk("timeout_xpos", 32'(bus.xpos), 32'd402);
      chk("timeout_ypos", 32'(bus.ypos), 32'd300);

      // X overflow freezes X only
      do_reset();
      send_pkt(8'h48, 8'h10, 8'h03);
      idle(3);
      chk("ovf_xpos", 32'(bus.xpos), 32'd400);
      chk("ovf_ypos", 32'(bus.ypos), 32'd297);
`ifdef MOUSE_ACCEL_EN
      do_reset();
      send_pkt(8'h08, 8'h10, 8'h00);
      idle(3);
      chk("accel_xpos", 32'(bus.xpos), 32'd432);
`endif

      // next packet's first byte lands in the update cycle
      do_reset();
      send_pkt(8'h08, 8'h01, 8'h00);
      send_pkt(8'h0A, 8'h02, 8'h00);
      idle(4);
      chk("b2b_xpos", 32'(bus.xpos), 32'd403);
      chk("b2b_right", 32'(bus.right), 32'd1);

      // reset mid-packet discards the partial bytes
      do_reset();
      send_byte(8'h09);
      send_byte(8'h0A);
      do_reset();
      chk("midrst_xpos", 32'(bus.xpos), 32'd400);
      send_pkt(8'h08, 8'h01, 8'h00);
      idle(3);
      chk("midrst_after_xpos", 32'(bus.xpos), 32'd401);
      chk("midrst_after_left", 32'(bus.left), 32'd0);

      idle(5);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("pkt_count", 32'(pkt_seen), 32'(pkt_pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
